// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the interpolation output drain path.
package interp_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 40;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned BLOCK_W   = WORD_W * NUM_WORDS;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

endpackage

// File: rtl/output_block_reader_if.sv
// Block-in / word-out handshake bundle between filler, reader and frame writer.
interface output_block_reader_if;
  import interp_pkg::*;

  logic                 blk_valid;
  logic                 blk_ready;
  logic [BLOCK_W-1:0]   blk_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_W-1:0]    out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;

  // master is the reader itself; slave is the producer/consumer side
  modport master (
    input  blk_valid, blk_in, out_ready,
    output blk_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output blk_valid, blk_in, out_ready,
    input  blk_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/drain_word_counter.sv
// Word sequence counter for the drain path; clear wins over enable, flags the final word.
module drain_word_counter
  import interp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_L,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             term_o
);

  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idx_o  = cnt_q;
  assign term_o = (cnt_q == IDX_W'(NUM_WORDS - 1));

endmodule

// File: rtl/output_block_reader.sv
// Captures a full interpolated block in parallel and streams it out oldest word (MSBs) first.
module output_block_reader
  import interp_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  abort,
  output_block_reader_if.master bus,
  output logic                  busy,
  output logic                  done
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               done_q, done_d;
  logic               cnt_clr, cnt_en, cnt_last;
  logic [IDX_W-1:0]   cnt_idx;

  drain_word_counter u_cnt (
    .clock   (clock),
    .reset_L (reset_L),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .idx_o   (cnt_idx),
    .term_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort) begin
      // Clearing the buffer keeps out_data at zero whenever nothing is valid
      state_d = StIdle;
      buf_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.blk_valid) begin
            buf_d   = bus.blk_in;
            state_d = StSend;
            cnt_clr = 1'b1;
          end
        end
        StSend: begin
          if (bus.out_ready) begin
            buf_d = {buf_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
            if (cnt_last) begin
              state_d = StIdle;
              done_d  = 1'b1;
              cnt_clr = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  assign bus.blk_ready = (state_q == StIdle);
  assign bus.out_valid = (state_q == StSend);
  assign bus.out_data  = buf_q[BLOCK_W-1 -: WORD_W];
  assign bus.out_idx   = cnt_idx;
  assign bus.out_last  = cnt_last;
  assign busy          = (state_q == StSend);
  assign done          = done_q;

endmodule

// File: tb/tb_output_block_reader.sv
// Table-driven bench for output_block_reader: per-cycle vectors plus an async-reset sequence.
module tb_output_block_reader;
  import interp_pkg::*;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  logic abort   = 1'b0;
  logic busy, done;

  output_block_reader_if bus ();

  output_block_reader dut (
    .clock   (clock),
    .reset_L (reset_L),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          rst_n;
    bit          ab;
    bit          bv;
    bit          rdy;
    logic [1:0]  sel;
    bit          e_valid;
    bit          e_ready;
    bit          e_last;
    bit          e_done;
    logic [63:0] e_data;
    logic [5:0]  e_idx;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [63:0] word(input logic [1:0] sel, input int k);
    case (sel)
      2'd0:    return 64'(k);
      2'd1:    return {32'hC0DE_0000, 32'(k)};
      2'd2:    return {8{8'hAA}};
      default: return {8{8'hBB}};
    endcase
  endfunction

  function automatic logic [BLOCK_W-1:0] blk(input logic [1:0] sel);
    logic [BLOCK_W-1:0] b;
    for (int k = 0; k < int'(NUM_WORDS); k++) b[k*WORD_W +: WORD_W] = word(sel, k);
    return b;
  endfunction

  // Expected idle/reset outputs: nothing valid, reader ready, counters and data zero
  function automatic void push_idle(string nm, bit rst_n, bit bv, bit ab, bit rdy,
                                    logic [1:0] sel, bit ed);
    vec_t v;
    v.name = nm; v.rst_n = rst_n; v.ab = ab; v.bv = bv; v.rdy = rdy; v.sel = sel;
    v.e_valid = 1'b0; v.e_ready = 1'b1; v.e_last = 1'b0; v.e_done = ed;
    v.e_data = '0; v.e_idx = '0;
    vq.push_back(v);
  endfunction

  // Transfer i of a block carries that block's word NUM_WORDS-1-i
  function automatic void push_send(string nm, bit bv, bit ab, bit rdy, logic [1:0] sel,
                                    logic [1:0] dsel, int i);
    vec_t v;
    v.name = nm; v.rst_n = 1'b1; v.ab = ab; v.bv = bv; v.rdy = rdy; v.sel = sel;
    v.e_valid = 1'b1; v.e_ready = 1'b0; v.e_last = (i == int'(NUM_WORDS) - 1);
    v.e_done = 1'b0; v.e_data = word(dsel, int'(NUM_WORDS) - 1 - i); v.e_idx = 6'(i);
    vq.push_back(v);
  endfunction

  function automatic void push_full_block(string nm, logic [1:0] sel);
    push_idle({nm, "_cap"}, 1'b1, 1'b1, 1'b0, 1'b1, sel, 1'b0);
    for (int i = 0; i < int'(NUM_WORDS); i++) push_send(nm, 1'b0, 1'b0, 1'b1, sel, sel, i);
    push_idle({nm, "_done"}, 1'b1, 1'b0, 1'b0, 1'b1, sel, 1'b1);
    push_idle({nm, "_after"}, 1'b1, 1'b0, 1'b0, 1'b1, sel, 1'b0);
  endfunction

  task automatic check(input vec_t v);
    n_vec++;
    if (bus.out_valid !== v.e_valid || bus.blk_ready !== v.e_ready ||
        bus.out_last !== v.e_last || done !== v.e_done || busy !== v.e_valid ||
        bus.out_data !== v.e_data || bus.out_idx !== v.e_idx) begin
      n_bad++;
      $display("FAIL %s @%0t: got valid=%b ready=%b last=%b done=%b busy=%b data=%h idx=%0d; want valid=%b ready=%b last=%b done=%b busy=%b data=%h idx=%0d",
               v.name, $time, bus.out_valid, bus.blk_ready, bus.out_last, done, busy,
               bus.out_data, bus.out_idx, v.e_valid, v.e_ready, v.e_last, v.e_done,
               v.e_valid, v.e_data, v.e_idx);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    reset_L       = v.rst_n;
    abort         = v.ab;
    bus.blk_valid = v.bv;
    bus.out_ready = v.rdy;
    bus.blk_in    = blk(v.sel);
    #1;
    check(v);
  endtask

  initial begin
    vec_t v;
    int   n;
    int   j;
    bus.blk_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.blk_in    = '0;

    // Reset held with blk_valid high, then released with blk_valid low
    for (int i = 0; i < 3; i++) push_idle("reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    push_idle("release", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    push_idle("release", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    push_full_block("single", 2'd0);

    // Backpressure with out_ready pattern 1,0,0,1,0,0,...
    push_idle("bp_cap", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    n = 0; j = 0;
    while (n < int'(NUM_WORDS)) begin
      push_send("bp", 1'b0, 1'b0, (j % 3 == 0), 2'd1, 2'd1, n);
      if (j % 3 == 0) n++;
      j++;
    end
    push_idle("bp_done", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);

    // Back-to-back: B held on blk_in during A, captured in A's done cycle
    push_idle("b2b_capA", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < int'(NUM_WORDS); i++) push_send("b2b_A", 1'b1, 1'b0, 1'b1, 2'd3, 2'd2, i);
    push_idle("b2b_capB", 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    for (int i = 0; i < int'(NUM_WORDS); i++) push_send("b2b_B", 1'b0, 1'b0, 1'b1, 2'd3, 2'd3, i);
    push_idle("b2b_done", 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);

    // Abort at idx 10, abort in idle with blk_valid, then a clean block
    push_idle("ab_cap", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) push_send("ab_pre", 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, i);
    push_send("ab_hit", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 10);
    push_idle("ab_idle", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    push_idle("ab_nocap", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    push_full_block("ab_next", 2'd1);

    // Abort coincident with the last-word transfer: no done pulse
    push_idle("ablast_cap", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 39; i++) push_send("ablast", 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, i);
    push_send("ablast_hit", 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 39);
    push_idle("ablast_nodone", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);

    // Lead-in for the async reset case: stream up to idx 20
    push_idle("ar_cap", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 20; i++) push_send("ar_pre", 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, i);

    foreach (vq[i]) apply(vq[i]);

    // Async reset between edges at idx 20: outputs clear with no clock edge
    v.name = "ar_stall"; v.rst_n = 1'b1; v.ab = 1'b0; v.bv = 1'b0; v.rdy = 1'b0; v.sel = 2'd1;
    v.e_valid = 1'b1; v.e_ready = 1'b0; v.e_last = 1'b0; v.e_done = 1'b0;
    v.e_data = word(2'd1, 19); v.e_idx = 6'd20;
    apply(v);
    #2 reset_L = 1'b0;
    #1;
    v.name = "ar_async"; v.rst_n = 1'b0; v.rdy = 1'b1;
    v.e_valid = 1'b0; v.e_ready = 1'b1; v.e_data = '0; v.e_idx = '0;
    check(v);
    bus.out_ready = 1'b1;
    apply(v);
    v.name = "ar_drained"; v.rst_n = 1'b1;
    for (int i = 0; i < 45; i++) apply(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/output_block_reader.md
Name: output_block_reader

Overview:
- Drain end of the interpolation output path.
- Accepts one fully-filled interpolated block (40 × 64-bit words, 2560 bits) as a single parallel handoff from the output filler stage.
- Streams the block out one word per transfer over a valid/ready interface to the frame writer.
- Emits words in production order: oldest word (MSBs of the block) first.

Parameters:
WORD_W, 64, bits per output word (8 pixels × 8 bits)
NUM_WORDS, 40, words per block (8 rows × 5 fractional positions)
IDX_W, 6, width of word index; must satisfy 2^IDX_W >= NUM_WORDS

Ports:
clock  input  1  clock; all logic on rising edge
reset_L  input  1  reset, asynchronous, active-low
abort  input  1  synchronous flush; discards the current block
blk_valid  input  1  producer presents a full block on blk_in
blk_ready  output  1  reader can capture a block this cycle
blk_in  input  WORD_W*NUM_WORDS  parallel block; word k = blk_in[k*WORD_W +: WORD_W]
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  WORD_W  current word
out_idx  output  IDX_W  sequence number of the current word, 0 = first sent
out_last  output  1  high with the final word of the block (out_idx == NUM_WORDS-1)
busy  output  1  high while in SEND
done  output  1  one-cycle pulse in the cycle after the last word transfers

Behaviour:
- Reset: async assert (reset_L=0) forces state IDLE and clears the buffer.
  - Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, blk_ready=1.
  - Release is synchronous to clock.
  - Reset mid-block discards all remaining words; done is not pulsed.
- States: IDLE, SEND.
- IDLE:
  - blk_ready=1, out_valid=0.
  - Capture occurs when blk_valid && blk_ready at edge N: buffer <= blk_in, idx <= 0, state <= SEND.
  - At N+1: out_valid=1 and out_data = blk_in word NUM_WORDS-1.
  - Latency from capture to first word: 1 cycle.
- SEND:
  - blk_ready=0; blk_valid is ignored and the producer must hold.
  - Transfer occurs when out_valid && out_ready.
  - On transfer, the buffer shifts up by WORD_W (zero fill) and idx increments.
  - Next word is presented the cycle after the transfer; no bubble.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable.
- Word order: transfer i (i = 0..NUM_WORDS-1) carries blk_in word NUM_WORDS-1-i.
- Last word (out_last=1) transfer at edge M:
  - state <= IDLE, out_valid <= 0, done <= 1 for cycle M+1 only.
  - blk_ready=1 from M+1.
  - A new block cannot be captured in the same edge as the last transfer.
  - Minimum period: NUM_WORDS+1 cycles per block.
- abort (synchronous, highest priority after reset):
  - Forces IDLE at the next edge: out_valid=0, idx=0, no done pulse.
  - abort in IDLE with blk_valid=1: no capture occurs.
  - abort coincident with a last-word transfer: the transfer counts, but done is suppressed.
- out_idx never exceeds NUM_WORDS-1; there is no wrap while in SEND.
- busy == (state == SEND).

Decomposition:
- Shared package (interp_pkg):
  - Constants: WORD_W=64, NUM_WORDS=40, BLOCK_W = WORD_W*NUM_WORDS.
  - State enumeration {IDLE, SEND}.
- One sub-module: drain_word_counter.
  - IDX_W-bit counter with clear, enable, and terminal flag at NUM_WORDS-1.
  - Drives out_idx and out_last.
- Shift buffer and FSM live in the top module.

Test Plan:
1. Reset then idle: reset_L=0 for 3 cycles with blk_valid=1 -> all outputs at reset values, blk_ready=1, no capture after release until blk_valid is sampled.
2. Single block with out_ready=1 always: word k = 64'h0000_0000_0000_00kk -> 40 transfers over 40 consecutive cycles starting 1 cycle after capture.
   - Data sequence 0x27, 0x26, … 0x00.
   - out_last only on the 40th transfer (out_idx=39).
   - done pulses the following cycle; blk_ready=1 that cycle.
3. Backpressure: out_ready toggles 1,0,0,1… -> no duplicates or drops; out_data stable across stall cycles; all 40 words in order; done after the 40th.
4. Back-to-back blocks A (0xAA…) then B (0xBB…), blk_valid held high -> B captured the cycle after A's done-triggering transfer; B's first word appears 41 cycles after A's first word.
5. abort at out_idx=10 -> out_valid=0 next cycle, no done, blk_ready=1; a following block streams from idx 0 correctly.
6. Async reset asserted mid-block (idx=20, between edges) -> outputs clear immediately without a clock edge; after release, no residual words are emitted.
